// File: rtl/seg_display_scan.sv
// Purpose: converts an ALU result to BCD (double-dabble) and scans it onto a common-anode 7-segment display.
// Latency: done pulses DATA_W+1 cycles after the accepting edge; segment/anode outputs lag the scan index by one cycle.
// Backpressure: in_ready is low from accept until done; in_valid is ignored while a conversion runs.
module seg_display_scan #(
  parameter int DATA_W      = 16,
  parameter int DIGITS      = 5,
  parameter int SIGNED_MODE = 1,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              display_en,
  output logic              done,
  output logic              overflow,
  output logic [6:0]        seg_n,
  output logic [DIGITS-1:0] an_n
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_e;

  // Team digit table, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 7'b1000000;
      4'd1:    digit_seg = 7'b1111001;
      4'd2:    digit_seg = 7'b0100100;
      4'd3:    digit_seg = 7'b0110000;
      4'd4:    digit_seg = 7'b0011001;
      4'd5:    digit_seg = 7'b0010010;
      4'd6:    digit_seg = 7'b0000010;
      4'd7:    digit_seg = 7'b1111000;
      4'd8:    digit_seg = 7'b0000000;
      4'd9:    digit_seg = 7'b0010000;
      default: digit_seg = SEG_BLANK;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic [DATA_W-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [BCD_W-1:0]    bcd_adj;
  logic                ovf_scr_q, ovf_scr_d;
  logic                ovf_bit;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic                commit;

  logic [6:0]          pat_q [DIGITS];
  logic [6:0]          pat_c [DIGITS];
  logic                ovf_c;
  int                  msd;
  logic                overflow_q, done_q;
  // Cleared by reset, set by the first commit: keeps every anode dark until real digits exist.
  logic                lit_q;

  logic [REF_W-1:0]    ref_q;
  logic [IDX_W-1:0]    idx_q;
  logic [6:0]          seg_n_q;
  logic [DIGITS-1:0]   an_n_q;

  // Double-dabble correction: add 3 to every nibble that is 5 or more before the shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
  end

  // Next-state logic for the accept / convert / commit sequence.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    bcd_d     = bcd_q;
    ovf_scr_d = ovf_scr_q;
    bitcnt_d  = bitcnt_q;
    ovf_bit   = 1'b0;
    commit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d    = (SIGNED_MODE != 0) && in_data[DATA_W-1];
          mag_d     = sign_d ? -in_data : in_data;
          bcd_d     = '0;
          ovf_scr_d = 1'b0;
          bitcnt_d  = CNT_W'(DATA_W);
          state_d   = S_CONVERT;
        end
      end
      S_CONVERT: begin
        {ovf_bit, bcd_d} = {bcd_adj, mag_q[DATA_W-1]};
        mag_d     = mag_q << 1;
        ovf_scr_d = ovf_scr_q | ovf_bit;
        bitcnt_d  = bitcnt_q - CNT_W'(1);
        if (bitcnt_q == CNT_W'(1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        commit  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Display patterns from the finished BCD: blank leading zeros, minus above msd, "E" on overflow.
  always_comb begin
    msd = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = i;
    end
    ovf_c = ovf_scr_q || (sign_q && (msd == DIGITS - 1));
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf_c)                      pat_c[i] = SEG_E;
      else if (i <= msd)              pat_c[i] = digit_seg(bcd_q[4*i +: 4]);
      else if (sign_q && i == msd + 1) pat_c[i] = SEG_MINUS;
      else                            pat_c[i] = SEG_BLANK;
    end
  end

  // Conversion state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      bcd_q     <= '0;
      ovf_scr_q <= 1'b0;
      bitcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      bcd_q     <= bcd_d;
      ovf_scr_q <= ovf_scr_d;
      bitcnt_q  <= bitcnt_d;
    end
  end

  // Committed display contents; overflow holds until the next commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) pat_q[i] <= SEG_BLANK;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      lit_q      <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit) begin
        for (int i = 0; i < DIGITS; i++) pat_q[i] <= pat_c[i];
        overflow_q <= ovf_c;
        lit_q      <= 1'b1;
      end
    end
  end

  // Free-running scan: refresh divider, position index and registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q   <= '0;
      idx_q   <= '0;
      seg_n_q <= SEG_BLANK;
      an_n_q  <= '1;
    end else begin
      if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
        ref_q <= '0;
        idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
        ref_q <= ref_q + REF_W'(1);
      end
      if (display_en && lit_q) begin
        seg_n_q <= pat_q[idx_q];
        an_n_q  <= ~(DIGITS'(1) << idx_q);
      end else begin
        seg_n_q <= SEG_BLANK;
        an_n_q  <= '1;
      end
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign seg_n    = seg_n_q;
  assign an_n     = an_n_q;

endmodule
